// File: rtl/addsub_serial.sv
// ============================================================================
// Module   : addsub_serial
// Purpose  : Multi-cycle add/subtract unit, CHUNK bits per clock, LSB chunk
//            first, with carry/overflow/zero/negative flags and valid/ready
//            handshakes. Optional macro ADDSUB_SAT_EN enables signed saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDXW-1:0]  c_LAST = IDXW'(N - 1);
`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] c_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_c;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_carry_f;
    logic              r_ovf;
    logic              r_zero;
    logic              r_neg;

    logic [CHUNK:0]    w_sum;
    logic [WIDTH-1:0]  w_c_full;
    logic [WIDTH-1:0]  w_c_final;
    logic              w_ovf;

    // r_b already holds ~b for subtraction and r_carry starts at 1, so this
    // single adder covers both a + b and a + ~b + 1.
    always_comb begin
        w_sum    = {1'b0, r_a[int'(r_idx) * CHUNK +: CHUNK]}
                 + {1'b0, r_b[int'(r_idx) * CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, r_carry};
        w_c_full = r_c;
        w_c_full[int'(r_idx) * CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
        w_ovf    = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                   (w_c_full[WIDTH-1] != r_a[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
        w_c_final = w_ovf ? (r_a[WIDTH-1] ? c_SAT_MIN : c_SAT_MAX) : w_c_full;
`else
        w_c_final = w_c_full;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_carry_f   <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= sub ? ~b : b;
                        r_carry    <= sub;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_carry <= w_sum[CHUNK];
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == c_LAST) begin
                        r_c         <= w_c_final;
                        r_carry_f   <= w_sum[CHUNK];
                        r_ovf       <= w_ovf;
                        r_zero      <= (w_c_final == '0);
                        r_neg       <= w_c_final[WIDTH-1];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_c <= w_c_full;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign c         = r_c;
    assign carry     = r_carry_f;
    assign overflow  = r_ovf;
    assign zero      = r_zero;
    assign negative  = r_neg;

endmodule

`default_nettype wire

// File: tb/tb_addsub_serial.sv
// ============================================================================
// Module   : tb_addsub_serial
// Purpose  : Directed self-checking bench for addsub_serial (WIDTH=32, CHUNK=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        negative;

    int n_pass  = 0;
    int n_total = 0;

    addsub_serial #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    always #5 clk = ~clk;

    // Flags packed as {carry, overflow, zero, negative}
    function automatic logic [3:0] flags();
        return {carry, overflow, zero, negative};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation and wait (bounded) for out_valid; checks latency.
    task automatic start_op(input string tag, input logic s, input logic [31:0] va,
                            input logic [31:0] vb);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        sub      = s;
        a        = va;
        b        = vb;
        tick();
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1234_5678;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 32'd4);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_in_ready"},  {31'd0, in_ready},  32'd1);
        check({tag, "_idle_out_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_c",         c,                  32'd0);
        check("rst_flags",     {28'd0, flags()},   32'd0);

        // 5 - 3 = 2, no borrow
        start_op("sub53", 1'b1, 32'd5, 32'd3);
        check("sub53_c",     c,                32'd2);
        check("sub53_flags", {28'd0, flags()}, 32'b1000);
        consume("sub53");

        // zero subtrahend: carry-in of 1 still yields a carry out
        start_op("sub50", 1'b1, 32'd5, 32'd0);
        check("sub50_c",     c,                32'd5);
        check("sub50_flags", {28'd0, flags()}, 32'b1000);
        consume("sub50");

        // 3 - 5 borrows: negative result, carry 0
        start_op("sub35", 1'b1, 32'd3, 32'd5);
        check("sub35_c",     c,                32'hFFFF_FFFE);
        check("sub35_flags", {28'd0, flags()}, 32'b0001);
        consume("sub35");

        // signed overflow on add
        start_op("addovf", 1'b0, 32'h7FFF_FFFF, 32'd1);
`ifdef ADDSUB_SAT_EN
        check("addovf_c",     c,                32'h7FFF_FFFF);
        check("addovf_flags", {28'd0, flags()}, 32'b0100);
`else
        check("addovf_c",     c,                32'h8000_0000);
        check("addovf_flags", {28'd0, flags()}, 32'b0101);
`endif
        consume("addovf");

        // backpressure: DONE held with inputs toggling
        start_op("bp", 1'b0, 32'd10, 32'd20);
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid;
            a        = a + 32'h0101_0101;
            b        = ~b;
            sub      = ~sub;
            tick();
            check("bp_c",         c,                  32'd30);
            check("bp_flags",     {28'd0, flags()},   32'b0000);
            check("bp_in_ready",  {31'd0, in_ready},  32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        consume("bp");

        // reset after two RUN cycles discards the operation
        in_valid = 1'b1;
        sub      = 1'b0;
        a        = 32'h1111_1111;
        b        = 32'h2222_2222;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_c",         c,                  32'd0);

        // wrap to zero with carry out
        start_op("wrap", 1'b0, 32'hFFFF_FFFF, 32'd1);
        check("wrap_c",     c,                32'd0);
        check("wrap_flags", {28'd0, flags()}, 32'b1010);
        consume("wrap");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle add/subtract unit that processes its operands CHUNK bits per clock, least-significant chunk first. It replaces the fixed 32-bit combinational subtractor on area-constrained paths. A single `sub` control selects the operation, and the block reports carry, signed overflow, zero and negative flags. Valid/ready handshakes on input and output let it sit between pipeline stages of the datapath without glue logic.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK
- CHUNK, 8, bits processed per RUN cycle; N = WIDTH/CHUNK

Ports:
- clk  input  1  single clock, all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept an operation (high only in IDLE)
- a  input  WIDTH  first operand
- b  input  WIDTH  second operand
- sub  input  1  0: c = a + b; 1: c = a − b
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts the result
- c  output  WIDTH  result
- carry  output  1  carry out of the MSB; for sub, 1 = no borrow (a ≥ b unsigned)
- overflow  output  1  two's-complement signed overflow
- zero  output  1  c == 0
- negative  output  1  c[WIDTH−1]

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch a, latch (sub ? ~b : b), latch sub; set the carry register to sub; clear the chunk index; go to RUN.
- RUN:
  - Each cycle adds chunk[idx] of a, chunk[idx] of the stored b, and the carry register.
  - Writes the CHUNK-bit sum into c[idx], updates the carry register, then increments idx.
  - After chunk N−1, goes to DONE.
- Subtraction always uses a + ~b + 1. The carry-in of 1 is applied in the datapath, so b = 0 needs no special case.
- Flags are computed at the transition into DONE:
  - carry = final carry.
  - overflow = (a[MSB] == b_eff[MSB]) && (c[MSB] != a[MSB]), where b_eff is the stored, possibly inverted, b.
  - zero and negative are computed on the final c.
- DONE:
  - out_valid = 1; c and the flags are held stable.
  - On out_valid && out_ready: go to IDLE.
- in_valid is ignored outside IDLE. Operands may change freely after acceptance.
- Reset (any state, including mid-RUN):
  - Next state is IDLE; the in-flight operation is discarded.
  - Reset values: in_ready = 1, out_valid = 0, c = 0, carry = overflow = zero = negative = 0.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - Internal carry is 1 bit between chunks.
  - idx width is clog2(N), with a minimum of 1.

## Timing
- Accept at edge k → RUN occupies edges k+1 … k+N → out_valid is high from edge k+N.
- Latency is N cycles from accept to result (4 at the defaults).
- Minimum initiation interval is N+2 cycles: accept, N RUN cycles, one DONE cycle with out_ready = 1, then IDLE.
- No new operation is accepted in the same cycle a result is consumed; in_ready rises the cycle after the DONE→IDLE transition.
- Backpressure: DONE persists for any number of cycles with out_ready = 0, and all outputs stay unchanged.
- N = 1 (CHUNK = WIDTH) is legal: a single RUN cycle, latency 1.

## Configuration
- ADDSUB_SAT_EN defined:
  - When overflow = 1, c saturates toward the sign of a: 100…0 if a[MSB] = 1, otherwise 011…1.
  - The overflow flag still reads 1; zero and negative reflect the saturated c; carry is unchanged.
  - Saturation is applied at the RUN→DONE transition, so latency is unchanged.
- ADDSUB_SAT_EN undefined: c wraps modulo 2^WIDTH.

## Test plan
All cases use WIDTH = 32, CHUNK = 8.
- sub = 1, a = 5, b = 3, out_ready = 1 → out_valid exactly 4 cycles after accept; c = 2, carry = 1, overflow = 0, zero = 0, negative = 0; in_ready returns after DONE.
- sub = 1, a = 5, b = 0 → c = 5, carry = 1, overflow = 0 (zero-subtrahend corner).
- sub = 1, a = 3, b = 5 → c = 0xFFFFFFFE, carry = 0, negative = 1, overflow = 0.
- sub = 0, a = 0x7FFFFFFF, b = 1:
  - Without the macro → c = 0x80000000, overflow = 1, negative = 1, carry = 0.
  - With ADDSUB_SAT_EN → c = 0x7FFFFFFF, overflow = 1, negative = 0.
- Backpressure: complete an op, hold out_ready = 0 for 3 cycles while toggling a, b and in_valid → c and flags stable, in_ready = 0, no second accept. Raise out_ready → IDLE next cycle.
- Reset asserted for one cycle after 2 RUN cycles → next cycle in_ready = 1, out_valid = 0, c = 0. A following op sub = 0, a = 0xFFFFFFFF, b = 1 → c = 0, carry = 1, zero = 1, overflow = 0.
